// File: rtl/spi_egress_pkg.sv
// rtl/spi_egress_pkg.sv - shared types and width helpers for the SPI MISO egress path
package spi_egress_pkg;

    typedef enum logic {OPEN = 1'b0, DONE = 1'b1} egress_state_t;

    function automatic int beats(input int w);
        return 8 / w;
    endfunction

    function automatic bit miso_width_legal(input int w);
        return (w == 1) || (w == 2) || (w == 4) || (w == 8);
    endfunction

endpackage

// File: rtl/spi_egress_shifter.sv
// rtl/spi_egress_shifter.sv - byte shift register, beat counter and tri-stated MISO lane select
module spi_egress_shifter
    import spi_egress_pkg::*;
#(
    parameter int         MISO_WIDTH = 1,
    parameter bit         MSB_FIRST  = 1'b1,
    parameter logic [7:0] IDLE_BYTE  = 8'h00
) (
    input  logic                  spi_clk,
    input  logic                  spi_csn,
    input  logic                  load,
    input  logic [7:0]            load_byte,
    output logic                  last_beat,
    output logic [MISO_WIDTH-1:0] miso
);

    localparam int BEATS = beats(MISO_WIDTH);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [7:0]            shreg;
    logic [BW-1:0]         beat;
    logic [MISO_WIDTH-1:0] lanes;

    assign last_beat = (beat == BW'(BEATS - 1));

    always_ff @(posedge spi_clk or posedge spi_csn) begin
        if (spi_csn) begin
            shreg <= IDLE_BYTE;
            beat  <= '0;
        end else if (load) begin
            shreg <= load_byte;
            beat  <= '0;
        end else begin
            shreg <= MSB_FIRST ? (shreg << MISO_WIDTH) : (shreg >> MISO_WIDTH);
            beat  <= beat + BW'(1);
        end
    end

    if (MSB_FIRST) begin : g_msb
        assign lanes = shreg[7 -: MISO_WIDTH];
    end else begin : g_lsb
        assign lanes = shreg[MISO_WIDTH-1:0];
    end

    // Lanes float whenever the slave is deselected so other slaves can share the bus.
    assign miso = spi_csn ? {MISO_WIDTH{1'bz}} : lanes;

endmodule

// File: rtl/spi_slave_axis_egress_mw.sv
// rtl/spi_slave_axis_egress_mw.sv - SPI slave MISO serialiser draining an 8-bit AXI-Stream with MTU, tlast and fill
module spi_slave_axis_egress_mw
    import spi_egress_pkg::*;
#(
    parameter int         MISO_WIDTH = 1,
    parameter bit         MSB_FIRST  = 1'b1,
    parameter int         MTU_SIZE   = 16,
    parameter logic [7:0] IDLE_BYTE  = 8'h00,
    parameter int         CNT_W      = 8
) (
    input  logic                  spi_clk,
    input  logic                  spi_csn,
    output logic [MISO_WIDTH-1:0] spi_miso,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic [7:0]            s_axis_tuser,
    output logic [CNT_W-1:0]      frame_bytes,
    output logic                  frame_done,
    output logic                  underrun
);

    localparam bit             WIDTH_OK = miso_width_legal(MISO_WIDTH);
    localparam logic [CNT_W:0] MTU_CMP  = (CNT_W + 1)'(MTU_SIZE);

    if (!WIDTH_OK) begin : g_bad_width
        $error("MISO_WIDTH must be 1, 2, 4 or 8");
    end

    egress_state_t    state, state_nxt;
    logic [CNT_W-1:0] bytes_nxt;
    logic [CNT_W:0]   bytes_inc;
    logic             underrun_nxt;
    logic             last_beat;
    logic             accept;
    logic [7:0]       load_byte;

    // One transfer opportunity per byte slot, decoded purely from registered state.
    assign s_axis_tready = !spi_csn && (state == OPEN) && last_beat;
    assign accept        = s_axis_tready && s_axis_tvalid;
    assign load_byte     = accept ? s_axis_tdata : s_axis_tuser;
    assign frame_done    = (state == DONE);
    assign bytes_inc     = {1'b0, frame_bytes} + (CNT_W + 1)'(1);

    always_ff @(posedge spi_clk or posedge spi_csn) begin
        if (spi_csn) begin
            state       <= OPEN;
            frame_bytes <= '0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_nxt;
            frame_bytes <= bytes_nxt;
            underrun    <= underrun_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bytes_nxt    = frame_bytes;
        underrun_nxt = underrun;
        if (last_beat && (state == OPEN)) begin
            if (accept) begin
                if (frame_bytes != '1) bytes_nxt = bytes_inc[CNT_W-1:0];
                if (s_axis_tlast || ((MTU_SIZE != 0) && (bytes_inc == MTU_CMP))) state_nxt = DONE;
            end else begin
                underrun_nxt = 1'b1;
            end
        end
    end

    spi_egress_shifter #(
        .MISO_WIDTH (MISO_WIDTH),
        .MSB_FIRST  (MSB_FIRST),
        .IDLE_BYTE  (IDLE_BYTE)
    ) u_shifter (
        .spi_clk   (spi_clk),
        .spi_csn   (spi_csn),
        .load      (last_beat),
        .load_byte (load_byte),
        .last_beat (last_beat),
        .miso      (spi_miso)
    );

endmodule

// File: tb/tb_spi_slave_axis_egress_mw.sv
// tb/tb_spi_slave_axis_egress_mw.sv - scoreboard bench for the SPI MISO egress serialiser
module tb_spi_slave_axis_egress_mw;

    typedef struct packed {
        logic [1:0] miso;
        logic       rdy;
        logic       done;
        logic [7:0] cnt;
        logic       und;
    } exp_t;

    logic       spi_clk = 1'b0;
    logic       csn1 = 1'b1, csn2 = 1'b1;
    logic [7:0] tdata = 8'h00, tuser = 8'hEE;
    logic       tvalid = 1'b0, tlast = 1'b0;

    logic       miso1, rdy1, done1, und1;
    logic [7:0] cnt1;
    logic [1:0] miso2;
    logic       rdy2, done2, und2;
    logic [7:0] cnt2;

    exp_t q1[$];
    exp_t q2[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 spi_clk = ~spi_clk;

    spi_slave_axis_egress_mw #(
        .MISO_WIDTH (1), .MSB_FIRST (1'b1), .MTU_SIZE (4), .IDLE_BYTE (8'h3C), .CNT_W (8)
    ) u_dut (
        .spi_clk (spi_clk), .spi_csn (csn1), .spi_miso (miso1),
        .s_axis_tdata (tdata), .s_axis_tvalid (tvalid), .s_axis_tlast (tlast),
        .s_axis_tready (rdy1), .s_axis_tuser (tuser),
        .frame_bytes (cnt1), .frame_done (done1), .underrun (und1)
    );

    spi_slave_axis_egress_mw #(
        .MISO_WIDTH (2), .MSB_FIRST (1'b0), .MTU_SIZE (16), .IDLE_BYTE (8'h00), .CNT_W (8)
    ) u_dut2 (
        .spi_clk (spi_clk), .spi_csn (csn2), .spi_miso (miso2),
        .s_axis_tdata (tdata), .s_axis_tvalid (tvalid), .s_axis_tlast (tlast),
        .s_axis_tready (rdy2), .s_axis_tuser (tuser),
        .frame_bytes (cnt2), .frame_done (done2), .underrun (und2)
    );

    // Monitor: every negedge inside a frame consumes one expected sample.
    always @(negedge spi_clk) begin
        exp_t e, a;
        if (!csn1) begin
            a = '{miso: {1'b0, miso1}, rdy: rdy1, done: done1, cnt: cnt1, und: und1};
            n_vec++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL dut1_unexpected_sample: got %p, required none", a);
            end else begin
                e = q1.pop_front();
                if (a !== e) begin
                    n_err++;
                    $display("FAIL dut1_sample t=%0t: got %p, required %p", $time, a, e);
                end
            end
        end
        if (!csn2) begin
            a = '{miso: miso2, rdy: rdy2, done: done2, cnt: cnt2, und: und2};
            n_vec++;
            if (q2.size() == 0) begin
                n_err++;
                $display("FAIL dut2_unexpected_sample: got %p, required none", a);
            end else begin
                e = q2.pop_front();
                if (a !== e) begin
                    n_err++;
                    $display("FAIL dut2_sample t=%0t: got %p, required %p", $time, a, e);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        tvalid = v;
        tdata  = d;
        tlast  = l;
    endtask

    // Queue n beats of one byte slot, then run the clock through them.
    task automatic slot_n(input int dut, input int n, input logic [7:0] b, input logic rdy,
                          input logic done, input logic [7:0] cnt, input logic und);
        exp_t e;
        int   nb;
        nb = (dut == 1) ? 8 : 4;
        for (int j = 0; j < n; j++) begin
            e.miso = (dut == 1) ? {1'b0, b[7-j]} : b[2*j +: 2];
            e.rdy  = rdy && (j == nb - 1);
            e.done = done;
            e.cnt  = cnt;
            e.und  = und;
            if (dut == 1) q1.push_back(e);
            else          q2.push_back(e);
        end
        repeat (n) @(posedge spi_clk);
        #1;
    endtask

    task automatic slot(input int dut, input logic [7:0] b, input logic rdy,
                        input logic done, input logic [7:0] cnt, input logic und);
        slot_n(dut, (dut == 1) ? 8 : 4, b, rdy, done, cnt, und);
    endtask

    task automatic check_idle(input int dut);
        logic [1:0] m;
        logic [1:0] mz;
        logic       r, d, u;
        logic [7:0] c;
        if (dut == 1) begin
            m = {1'bz, miso1}; mz = 2'bzz; r = rdy1; d = done1; u = und1; c = cnt1;
        end else begin
            m = miso2; mz = 2'bzz; r = rdy2; d = done2; u = und2; c = cnt2;
        end
        n_vec++;
        if (m !== mz || r !== 1'b0 || d !== 1'b0 || u !== 1'b0 || c !== 8'h00) begin
            n_err++;
            $display("FAIL dut%0d_idle: got miso=%b rdy=%b done=%b und=%b cnt=%0d, required miso=zz rdy=0 done=0 und=0 cnt=0",
                     dut, m, r, d, u, c);
        end
    endtask

    task automatic gap;
        @(posedge spi_clk);
        #1;
    endtask

    initial begin
        @(posedge spi_clk);
        #1;
        check_idle(1);
        check_idle(2);

        // 2-lane LSB-first: 1B as lane pairs 11,10,01,00; tvalid dropped so EE fills slot 2.
        tuser = 8'hEE;
        drive(1'b1, 8'h1B, 1'b0);
        csn2 = 1'b0;
        slot(2, 8'h00, 1'b1, 1'b0, 8'd0, 1'b0);
        drive(1'b0, 8'h1B, 1'b0);
        slot(2, 8'h1B, 1'b1, 1'b0, 8'd1, 1'b0);
        slot(2, 8'hEE, 1'b1, 1'b0, 8'd1, 1'b1);
        csn2 = 1'b1;
        #1;
        check_idle(2);
        gap();

        // Frame A: A5 after IDLE 3C, one underrun slot, then MTU=4 closes the frame.
        csn1 = 1'b0;
        drive(1'b1, 8'hA5, 1'b0);
        slot(1, 8'h3C, 1'b1, 1'b0, 8'd0, 1'b0);
        drive(1'b0, 8'h11, 1'b0);
        slot(1, 8'hA5, 1'b1, 1'b0, 8'd1, 1'b0);
        drive(1'b1, 8'h02, 1'b0);
        slot(1, 8'hEE, 1'b1, 1'b0, 8'd1, 1'b1);
        drive(1'b1, 8'h03, 1'b0);
        slot(1, 8'h02, 1'b1, 1'b0, 8'd2, 1'b1);
        drive(1'b1, 8'h04, 1'b0);
        slot(1, 8'h03, 1'b1, 1'b0, 8'd3, 1'b1);
        drive(1'b1, 8'h05, 1'b0);
        slot(1, 8'h04, 1'b0, 1'b1, 8'd4, 1'b1);
        slot(1, 8'hEE, 1'b0, 1'b1, 8'd4, 1'b1);
        csn1 = 1'b1;
        gap();

        // Frame B: 01..04 accepted, 05 left on the bus, then tuser fill.
        csn1 = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            if (i <= 5) slot(1, (i == 1) ? 8'h3C : 8'(i - 1), i <= 4, i == 5, 8'(i - 1), 1'b0);
        end
        drive(1'b1, 8'h05, 1'b0);
        slot(1, 8'hEE, 1'b0, 1'b1, 8'd4, 1'b0);
        csn1 = 1'b1;
        gap();

        // Frame C: tlast on the first payload byte closes the frame.
        csn1 = 1'b0;
        drive(1'b1, 8'h07, 1'b1);
        slot(1, 8'h3C, 1'b1, 1'b0, 8'd0, 1'b0);
        drive(1'b1, 8'h08, 1'b0);
        slot(1, 8'h07, 1'b0, 1'b1, 8'd1, 1'b0);
        slot(1, 8'hEE, 1'b0, 1'b1, 8'd1, 1'b0);
        csn1 = 1'b1;
        gap();

        // Frame D: csn rises three edges into byte 55.
        csn1 = 1'b0;
        drive(1'b1, 8'h55, 1'b0);
        slot(1, 8'h3C, 1'b1, 1'b0, 8'd0, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        slot_n(1, 3, 8'h55, 1'b1, 1'b0, 8'd1, 1'b0);
        csn1 = 1'b1;
        #1;
        check_idle(1);
        gap();

        // Frame E: fresh frame restarts at IDLE with cleared counters.
        csn1 = 1'b0;
        slot(1, 8'h3C, 1'b1, 1'b0, 8'd0, 1'b0);
        slot(1, 8'hEE, 1'b1, 1'b0, 8'd0, 1'b1);
        csn1 = 1'b1;
        gap();

        n_vec++;
        if (q1.size() != 0 || q2.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d/%0d left, required 0/0", q1.size(), q2.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
